// File: rtl/chip8_sprite_pkg.sv
// CHIP-8 sprite drawer shared types and geometry.
// Framebuffer is 64x32 pixels, accessed 8 pixels per word.
package chip8_sprite_pkg;

  localparam int FB_WIDTH  = 64;
  localparam int FB_HEIGHT = 32;
  localparam int ACCESS_W  = 8;

  typedef enum logic [2:0] {
    IDLE,
    MEM,
    FB_RD,
    FB_WR,
    WRAP_RD,
    WRAP_WR,
    DONE
  } state_t;

endpackage

// File: rtl/chip8_sprite_row_align.sv
// Aligns one sprite byte onto an 8-pixel framebuffer word.
// p covers word xa, p2 the spill into word 0.
module chip8_sprite_row_align
  import chip8_sprite_pkg::*;
(
  input  logic [ACCESS_W-1:0] sprite,
  input  logic [2:0]          s,
  output logic [ACCESS_W-1:0] p,
  output logic [ACCESS_W-1:0] p2
);

  logic [ACCESS_W-1:0] rev;

  // MSB is leftmost pixel; fb bit k is pixel x+k, so reverse
  always_comb begin
    rev = '0;
    for (int k = 0; k < ACCESS_W; k++)
      rev[k] = sprite[ACCESS_W-1-k];
    p  = rev << s;
    p2 = rev >> (4'd8 - {1'b0, s});
  end

endmodule

// File: rtl/chip8_sprite_drawer.sv
// CHIP-8 DRW engine: XOR sprite rows into the framebuffer.
// Define SPRITE_WRAP_EN to wrap pixels past x=63 / y=31.
module chip8_sprite_drawer
  import chip8_sprite_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  vx,
  input  logic [7:0]  vy,
  input  logic [3:0]  n,
  input  logic [11:0] i_reg,
  output logic [11:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  fbvx_read,
  output logic [7:0]  fbvy_read,
  input  logic [7:0]  fb_readdata,
  output logic [7:0]  fbvx_write,
  output logic [7:0]  fbvy_write,
  output logic [7:0]  fbdata,
  output logic        write,
  output logic        busy,
  output logic        done,
  output logic        collision
);

  localparam int X_MAX = FB_WIDTH - ACCESS_W;

  state_t      state;
  logic [5:0]  x0;
  logic [4:0]  y0;
  logic [3:0]  n_lat;
  logic [11:0] i_lat;
  logic [3:0]  r;
  logic [7:0]  sprite;
  logic        acc;

  logic [5:0]  xa;
  logic [2:0]  s;
  logic [5:0]  y_cur;
  logic [7:0]  y_row;
  logic [7:0]  p;
  logic [7:0]  p2;
  logic [7:0]  p_sel;
  logic        acc_nxt;
  logic [3:0]  r_nxt;
  logic        more;

  chip8_sprite_row_align u_align (
    .sprite (sprite),
    .s      (s),
    .p      (p),
    .p2     (p2)
  );

  // Row geometry, pixel pattern, collision and next-row decision
  always_comb begin
    xa      = (x0 > 6'(X_MAX)) ? 6'(X_MAX) : x0;
    s       = 3'(x0 - xa);
    y_cur   = {1'b0, y0} + {2'b0, r};
`ifdef SPRITE_WRAP_EN
    y_row   = 8'(y_cur & 6'(FB_HEIGHT - 1));
`else
    y_row   = 8'(y_cur);
`endif
    p_sel   = (state == WRAP_WR) ? p2 : p;
    acc_nxt = acc | (write & (|(fb_readdata & p_sel)));
    r_nxt   = r + 4'd1;
`ifdef SPRITE_WRAP_EN
    more    = (r_nxt < n_lat);
`else
    more    = (r_nxt < n_lat) &&
              (({1'b0, y0} + {2'b0, r_nxt}) < 6'(FB_HEIGHT));
`endif
  end

  // New pixels only flow while a write strobe is up
  assign fbdata = write ? (fb_readdata ^ p_sel) : 8'h00;
  assign busy   = (state != IDLE);

  // Draw sequencer with registered strobes and addresses
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      x0         <= '0;
      y0         <= '0;
      n_lat      <= '0;
      i_lat      <= '0;
      r          <= '0;
      sprite     <= '0;
      acc        <= 1'b0;
      mem_addr   <= '0;
      fbvx_read  <= '0;
      fbvy_read  <= '0;
      fbvx_write <= '0;
      fbvy_write <= '0;
      write      <= 1'b0;
      done       <= 1'b0;
      collision  <= 1'b0;
    end else begin
      done  <= 1'b0;
      write <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            x0        <= 6'(vx & 8'h3F);
            y0        <= 5'(vy & 8'h1F);
            n_lat     <= n;
            i_lat     <= i_reg;
            r         <= '0;
            acc       <= 1'b0;
            collision <= 1'b0;
            mem_addr  <= i_reg;
            state     <= MEM;
          end
        end
        MEM: begin
          if (n_lat == 4'd0) begin
            collision <= acc;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            fbvx_read <= {2'b0, xa};
            fbvy_read <= y_row;
            state     <= FB_RD;
          end
        end
        FB_RD: begin
          sprite     <= mem_rdata;
          fbvx_write <= {2'b0, xa};
          fbvy_write <= y_row;
          write      <= 1'b1;
          state      <= FB_WR;
        end
        FB_WR: begin
          acc <= acc_nxt;
`ifdef SPRITE_WRAP_EN
          if (s != 3'd0) begin
            fbvx_read <= '0;
            state     <= WRAP_RD;
          end else
`endif
          if (more) begin
            r        <= r_nxt;
            mem_addr <= i_lat + {8'b0, r_nxt};
            state    <= MEM;
          end else begin
            collision <= acc_nxt;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        WRAP_RD: begin
          fbvx_write <= '0;
          write      <= 1'b1;
          state      <= WRAP_WR;
        end
        WRAP_WR: begin
          acc <= acc_nxt;
          if (more) begin
            r        <= r_nxt;
            mem_addr <= i_lat + {8'b0, r_nxt};
            state    <= MEM;
          end else begin
            collision <= acc_nxt;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chip8_sprite_drawer.sv
// Bench for chip8_sprite_drawer: pixel-level DRW reference model,
// sprite/framebuffer memories and randomized draws.
module tb_chip8_sprite_drawer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  vx = '0;
  logic [7:0]  vy = '0;
  logic [3:0]  n = '0;
  logic [11:0] i_reg = '0;
  logic [11:0] mem_addr;
  logic [7:0]  mem_rdata = '0;
  logic [7:0]  fbvx_read;
  logic [7:0]  fbvy_read;
  logic [7:0]  fb_readdata = '0;
  logic [7:0]  fbvx_write;
  logic [7:0]  fbvy_write;
  logic [7:0]  fbdata;
  logic        write;
  logic        busy;
  logic        done;
  logic        collision;

  int tests = 0;
  int fails = 0;

  logic [7:0] smem [4096];
  bit         fb_ref [32][64];
  bit         fb_mem [32][64];
  int         wcount = 0;
  logic [7:0] lw_x = '0;
  logic [7:0] lw_y = '0;
  logic [7:0] lw_d = '0;

  chip8_sprite_drawer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .vx          (vx),
    .vy          (vy),
    .n           (n),
    .i_reg       (i_reg),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .fbvx_read   (fbvx_read),
    .fbvy_read   (fbvy_read),
    .fb_readdata (fb_readdata),
    .fbvx_write  (fbvx_write),
    .fbvy_write  (fbvy_write),
    .fbdata      (fbdata),
    .write       (write),
    .busy        (busy),
    .done        (done),
    .collision   (collision)
  );

  always #5 clk = ~clk;

  int         xx;
  logic [7:0] rd;

  always @(posedge clk) begin
    for (int k = 0; k < 8; k++) begin
      xx = int'(fbvx_read) + k;
      rd[k] = (xx < 64 && fbvy_read < 32) ? fb_mem[fbvy_read][xx] : 1'b0;
    end
    fb_readdata <= rd;
    mem_rdata   <= smem[mem_addr];
    if (write) begin
      wcount++;
      lw_x = fbvx_write;
      lw_y = fbvy_write;
      lw_d = fbdata;
      for (int k = 0; k < 8; k++) begin
        xx = int'(fbvx_write) + k;
        if (xx < 64 && fbvy_write < 32)
          fb_mem[fbvy_write][xx] = fbdata[k];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int fb_diff();
    int d = 0;
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 64; x++)
        if (fb_ref[y][x] != fb_mem[y][x]) d++;
    return d;
  endfunction

  // CHIP-8 DRW semantics pixel by pixel
  task automatic ref_draw(input logic [7:0] ax, input logic [7:0] ay,
                          input int nn, input logic [11:0] ai,
                          output bit coll, output int rows,
                          output int spills);
    int x0, y0, y, x;
    bit spilled;
    logic [7:0] b;
    x0 = int'(ax) % 64;
    y0 = int'(ay) % 32;
    coll = 0;
    rows = 0;
    spills = 0;
    for (int rr = 0; rr < nn; rr++) begin
      y = y0 + rr;
`ifdef SPRITE_WRAP_EN
      y = y % 32;
`else
      if (y > 31) continue;
`endif
      b = smem[(int'(ai) + rr) % 4096];
      rows++;
      spilled = 0;
      for (int c = 0; c < 8; c++) begin
        x = x0 + c;
        if (x > 63) begin
`ifdef SPRITE_WRAP_EN
          x = x - 64;
          spilled = 1;
`else
          continue;
`endif
        end
        if (b[7-c]) begin
          if (fb_ref[y][x]) coll = 1;
          fb_ref[y][x] = ~fb_ref[y][x];
        end
      end
      if (spilled) spills++;
    end
  endtask

  task automatic do_draw(input string tag, input logic [7:0] ax,
                         input logic [7:0] ay, input logic [3:0] an,
                         input logic [11:0] ai, input bit noise);
    bit ec, busy_ok;
    int rows, spills, exp_cyc, got_cyc, w0;
    ref_draw(ax, ay, int'(an), ai, ec, rows, spills);
    exp_cyc = (an == 0) ? 2 : 1 + 3 * rows + 2 * spills;
    @(negedge clk);
    vx = ax;
    vy = ay;
    n = an;
    i_reg = ai;
    start = 1'b1;
    w0 = wcount;
    got_cyc = -1;
    busy_ok = 1;
    for (int c = 1; c <= 120; c++) begin
      @(negedge clk);
      if (noise && c == 1) begin
        vx = ~ax;
        vy = ay + 8'd3;
        n = ~an;
        i_reg = ~ai;
      end else begin
        start = 1'b0;
      end
      if (!busy) busy_ok = 0;
      if (done) begin
        got_cyc = c;
        break;
      end
    end
    start = 1'b0;
    check({tag, "_done_cyc"}, got_cyc, exp_cyc);
    check({tag, "_coll"}, {31'b0, collision}, {31'b0, ec});
    check({tag, "_busy"}, {31'b0, busy_ok}, 32'd1);
    @(negedge clk);
    check({tag, "_idle"}, {30'b0, done, busy}, 32'd0);
    check({tag, "_coll_hold"}, {31'b0, collision}, {31'b0, ec});
    check({tag, "_writes"}, wcount - w0, rows + spills);
    check({tag, "_fb"}, fb_diff(), 0);
  endtask

  initial begin
    int w0;
    bit ec, saw_done;
    int rows, spills;

    for (int a = 0; a < 4096; a++) smem[a] = 8'($urandom);
    smem[12'h200] = 8'hF0;
    smem[12'h300] = 8'hFF;
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 64; x++) begin
        fb_ref[y][x] = 0;
        fb_mem[y][x] = 0;
      end

    repeat (3) @(negedge clk);
    check("rst_ctl", {28'b0, busy, done, write, collision}, 32'd0);
    check("rst_mem_addr", {20'b0, mem_addr}, 32'd0);
    check("rst_rd_addr", {16'b0, fbvx_read, fbvy_read}, 32'd0);
    check("rst_wr", {8'b0, fbvx_write, fbvy_write, fbdata}, 32'd0);
    reset = 1'b0;

    do_draw("blank_f0", 8'd8, 8'd0, 4'd1, 12'h200, 0);
    check("blank_f0_lw", {8'b0, lw_x, lw_y, lw_d}, {8'b0, 8'd8, 8'd0, 8'h0F});
    do_draw("again_f0", 8'd8, 8'd0, 4'd1, 12'h200, 0);
    check("again_f0_lw", {8'b0, lw_x, lw_y, lw_d}, {8'b0, 8'd8, 8'd0, 8'h00});
    check("again_f0_c", {31'b0, collision}, 32'd1);

    do_draw("xedge", 8'd60, 8'd10, 4'd1, 12'h300, 0);
`ifdef SPRITE_WRAP_EN
    check("xedge_lw", {8'b0, lw_x, lw_y, lw_d}, {8'b0, 8'd0, 8'd10, 8'h0F});
`else
    check("xedge_lw", {8'b0, lw_x, lw_y, lw_d}, {8'b0, 8'd56, 8'd10, 8'hF0});
`endif

    do_draw("yedge", 8'd0, 8'd30, 4'd4, 12'h400, 0);
    do_draw("n_zero", 8'd20, 8'd20, 4'd0, 12'h500, 1);
    do_draw("busy_start", 8'd24, 8'd12, 4'd3, 12'h600, 1);

    ref_draw(8'd16, 8'd5, 1, 12'h700, ec, rows, spills);
    @(negedge clk);
    vx = 8'd16;
    vy = 8'd5;
    n = 4'd3;
    i_reg = 12'h700;
    start = 1'b1;
    w0 = wcount;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_ctl", {29'b0, busy, done, write}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    saw_done = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    check("mid_rst_done", {31'b0, saw_done}, 32'd0);
    check("mid_rst_writes", wcount - w0, 32'd1);
    check("mid_rst_fb", fb_diff(), 0);

    for (int t = 0; t < 24; t++)
      do_draw($sformatf("rnd%0d", t), 8'($urandom), 8'($urandom),
              4'($urandom), 12'($urandom), t[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/chip8_sprite_drawer.md
CHIP8_SPRITE_DRAWER -- requirements
Module: chip8_sprite_drawer

Interface
REQ-001 SHALL have clk, input, 1, system clock; all state updates on its rising edge.
REQ-002 SHALL have reset, input, 1; reset is synchronous and active-high.
REQ-003 SHALL have start, input, 1, draw request; sampled only in IDLE.
REQ-004 SHALL have vx, input, 8; vy, input, 8; n, input, 4; i_reg, input, 12; sprite origin, row count and sprite base address, all latched on accepted start.
REQ-005 SHALL have mem_addr, output, 12; mem_rdata, input, 8; sprite memory has 1-cycle read latency.
REQ-006 SHALL have fbvx_read and fbvy_read, output, 8 each; fb_readdata, input, 8; registered, valid the cycle after the address is presented; bit k is pixel x+k.
REQ-007 SHALL have fbvx_write and fbvy_write, output, 8 each; fbdata, output, 8; write, output, 1; bit k of fbdata is written to pixel x+k.
REQ-008 SHALL have busy, output, 1; done, output, 1-cycle pulse; collision, output, 1, the CHIP-8 VF result.

Function
REQ-009 SHALL latch x0=vx mod 64, y0=vy mod 32, n and i_reg when start=1 in IDLE, then enter MEM; start is ignored while busy.
REQ-010 SHALL use states IDLE, MEM, FB_RD, FB_WR, WRAP_RD, WRAP_WR and DONE; busy=1 in every state except IDLE.
REQ-011 In MEM, SHALL drive mem_addr=(i_reg+r) mod 4096, where r is the row index 0..n-1.
REQ-012 In FB_RD, SHALL capture mem_rdata as the sprite byte and present the read address (xa, y0+r), where xa=min(x0,56) and s=x0-xa.
REQ-013 Sprite MSB is the leftmost pixel: SHALL form p = bit-reversed sprite byte shifted left by s, truncated to 8 bits.
REQ-014 In FB_WR, SHALL assert write for exactly 1 cycle with address (xa, y0+r) and fbdata = fb_readdata XOR p.
REQ-015 SHALL set the collision accumulator whenever (fb_readdata AND p) is nonzero, in both FB_WR and WRAP_WR.
REQ-016 After the last row, SHALL enter DONE, pulse done for 1 cycle, then return to IDLE.
REQ-017 Timing without spill: 3 cycles per row and done in cycle 3n+1 after the start edge; n=0 SHALL go MEM->DONE directly with collision=0 and no writes.
REQ-018 A row with y0+r>31 SHALL be clipped (no access) unless SPRITE_WRAP_EN is defined.
REQ-019 The collision output SHALL update when entering DONE and hold until the next accepted start; the accumulator is cleared on start.
REQ-020 write SHALL be 0 in all states except FB_WR and WRAP_WR; fbdata and the write address SHALL be stable while write=1.

Reset
REQ-021 Reset SHALL force IDLE with busy=0, done=0, write=0, collision=0, and mem_addr, fbvx_*, fbvy_* and fbdata all 0.
REQ-022 Reset mid-draw SHALL abort without issuing a further write or a done pulse; rows already written stay written.

Configuration
REQ-023 SPRITE_WRAP_EN defined: when s>0, SHALL add WRAP_RD and WRAP_WR after FB_WR to access (0, y0+r) with p2 = reversed sprite byte >> (8-s); this costs 2 extra cycles per row.
REQ-024 SPRITE_WRAP_EN defined: rows with y0+r>31 SHALL wrap to y=(y0+r) mod 32.
REQ-025 SPRITE_WRAP_EN undefined: pixels past x=63 and rows past y=31 SHALL be clipped, and WRAP_RD and WRAP_WR are unreachable.

Structure
REQ-026 Package chip8_sprite_pkg SHALL hold the state enum, FB_WIDTH=64, FB_HEIGHT=32 and ACCESS_W=8.
REQ-027 Sub-module chip8_sprite_row_align SHALL be combinational and produce p and p2 from the sprite byte and s; the FSM stays in chip8_sprite_drawer.

Verification
REQ-028 Blank fb, vx=8, vy=0, n=1, sprite 0xF0: SHALL write fbdata=0x0F at (8,0), done in cycle 4, collision=0.
REQ-029 Repeat the REQ-028 draw: SHALL write fbdata=0x00 at (8,0) and collision=1.
REQ-030 vx=60, n=1, sprite 0xFF: SHALL write 0xF0 at (56,y); with SPRITE_WRAP_EN, SHALL also write 0x0F at (0,y), giving done in cycle 6.
REQ-031 vy=30, n=4: without the macro, rows y=30 and 31 are drawn and done comes in cycle 7; with the macro, rows y=0 and 1 are also drawn.
REQ-032 n=0: SHALL produce done in cycle 2 with zero writes; start pulses while busy=1 SHALL be ignored.
REQ-033 Reset asserted in FB_RD of row 2: SHALL produce no write and no done after it, and busy=0 on the next cycle.
